// File: rtl/text_term_ctrl_pkg.sv
// Shared constants and types for the text terminal write path.
// The GPU display stage imports the same DEF_COLS / DEF_ROWS so its
// ROW_BASE and address math agrees with the controller.
package text_term_pkg;

  localparam int          DEF_COLS      = 50;     // characters per row (row stride)
  localparam int          DEF_ROWS      = 37;     // visible rows
  localparam logic [6:0]  DEF_FILL_CHAR = 7'h20;  // code written by clears

  localparam int AW = 11;  // framebuffer address width
  localparam int CW = 6;   // cursor / row-base width

  localparam logic [6:0] CHR_BS = 7'h08;
  localparam logic [6:0] CHR_LF = 7'h0A;
  localparam logic [6:0] CHR_FF = 7'h0C;
  localparam logic [6:0] CHR_CR = 7'h0D;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PUT,
    ST_CLR_ROW,
    ST_CLR_ALL
  } term_state_e;

  function automatic logic is_printable(input logic [6:0] c);
    return (c >= 7'h20) && (c <= 7'h7E);
  endfunction

endpackage

// File: rtl/text_term_ctrl_if.sv
// CPU-bus and framebuffer/status signal bundle for text_term_ctrl.
//   master : CPU side (drives CE, RW, DATA; observes everything else)
//   slave  : controller side (samples CE, RW, DATA; drives FB_* and status)
interface text_term_ctrl_if;
  import text_term_pkg::*;

  logic          CE;        // chip enable, active-low
  logic          RW;        // 1 = read, 0 = write
  logic [7:0]    DATA;      // write data, bit 7 ignored
  logic          FB_WE;     // framebuffer write strobe
  logic [AW-1:0] FB_ADDR;   // physical framebuffer address
  logic [6:0]    FB_DATA;   // character code
  logic [CW-1:0] ROW_BASE;  // physical row shown at screen top
  logic [CW-1:0] CURSOR_X;  // logical cursor column
  logic [CW-1:0] CURSOR_Y;  // logical cursor row
  logic          BUSY;      // sweep in progress
  logic          OVERRUN;   // sticky: write dropped while BUSY

  modport master (
    output CE, RW, DATA,
    input  FB_WE, FB_ADDR, FB_DATA, ROW_BASE, CURSOR_X, CURSOR_Y, BUSY, OVERRUN
  );

  modport slave (
    input  CE, RW, DATA,
    output FB_WE, FB_ADDR, FB_DATA, ROW_BASE, CURSOR_X, CURSOR_Y, BUSY, OVERRUN
  );

endinterface

// File: rtl/text_term_ctrl_addr_gen.sv
// term_addr_gen: combinational logical-to-physical address mapping.
//   row, base : logical row and row-base offset (both < ROWS)
//   col       : column (< COLS)
//   addr      : ((row + base) mod ROWS) * COLS + col
// Both operands are below ROWS, so the mod is a single compare-and-subtract.
module term_addr_gen
  import text_term_pkg::*;
#(
  parameter int COLS = DEF_COLS,
  parameter int ROWS = DEF_ROWS
) (
  input  logic [CW-1:0] row,
  input  logic [CW-1:0] base,
  input  logic [CW-1:0] col,
  output logic [AW-1:0] addr
);

  logic [CW:0]   sum;
  logic [CW-1:0] prow;

  always_comb begin
    sum  = {1'b0, row} + {1'b0, base};
    prow = (sum >= (CW+1)'(ROWS)) ? CW'(sum - (CW+1)'(ROWS)) : sum[CW-1:0];
    addr = AW'(int'(prow) * COLS + int'(col));
  end

endmodule

// File: rtl/text_term_ctrl.sv
// text_term_ctrl: terminal-style write controller for the character
// framebuffer. Decodes CPU byte writes into character stores and cursor
// moves, and runs clear-screen / scroll sweeps that write FILL_CHAR.
//   CLK_CPU, RST : clock, async active-low reset
//   bus (slave)  : CE/RW/DATA from the CPU; FB_WE/FB_ADDR/FB_DATA write
//                  request (registered), ROW_BASE, cursor, BUSY, OVERRUN
module text_term_ctrl
  import text_term_pkg::*;
#(
  parameter int         COLS      = DEF_COLS,
  parameter int         ROWS      = DEF_ROWS,
  parameter logic [6:0] FILL_CHAR = DEF_FILL_CHAR
) (
  input  logic             CLK_CPU,
  input  logic             RST,
  text_term_ctrl_if.slave  bus
);

  term_state_e   state_q, state_d;
  logic [CW-1:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [CW-1:0] row_base_q, row_base_d;
  logic [CW-1:0] sweep_row_q, sweep_row_d, sweep_col_q, sweep_col_d;
  logic          pend_scroll_q, pend_scroll_d;  // PUT must chain into a row sweep
  logic          fb_we_q, fb_we_d;
  logic [AW-1:0] fb_addr_q, fb_addr_d;
  logic [6:0]    fb_data_q, fb_data_d;
  logic          overrun_q, overrun_d;

  logic          sweeping, wr_req, accept, last_row;
  logic [6:0]    chr;
  logic [CW-1:0] ag_row, ag_base, ag_col, row_base_inc;
  logic [AW-1:0] ag_addr;

  // A PUT that wrapped into a scroll already counts as busy so the sweep
  // follows the character write with no gap.
  assign sweeping = (state_q == ST_CLR_ROW) || (state_q == ST_CLR_ALL) ||
                    ((state_q == ST_PUT) && pend_scroll_q);
  assign wr_req   = !bus.CE && !bus.RW;
  assign accept   = wr_req && !sweeping;
  assign chr      = bus.DATA[6:0];
  assign last_row = (cur_y_q == CW'(ROWS-1));
  assign row_base_inc = (row_base_q == CW'(ROWS-1)) ? '0 : row_base_q + 1'b1;

  // Sweeps address physical rows directly, so the base offset is zero.
  assign ag_row  = sweeping ? sweep_row_q : cur_y_q;
  assign ag_base = sweeping ? '0          : row_base_q;
  assign ag_col  = sweeping ? sweep_col_q : cur_x_q;

  term_addr_gen #(.COLS(COLS), .ROWS(ROWS)) u_addr_gen (
    .row  (ag_row),
    .base (ag_base),
    .col  (ag_col),
    .addr (ag_addr)
  );

  always_comb begin
    state_d       = state_q;
    cur_x_d       = cur_x_q;
    cur_y_d       = cur_y_q;
    row_base_d    = row_base_q;
    sweep_row_d   = sweep_row_q;
    sweep_col_d   = sweep_col_q;
    pend_scroll_d = pend_scroll_q;
    fb_we_d       = 1'b0;
    fb_addr_d     = fb_addr_q;
    fb_data_d     = fb_data_q;
    overrun_d     = overrun_q | (wr_req && sweeping);

    if (sweeping) begin
      fb_we_d       = 1'b1;
      fb_addr_d     = ag_addr;
      fb_data_d     = FILL_CHAR;
      pend_scroll_d = 1'b0;
      if ((sweep_col_q == CW'(COLS-1)) &&
          ((state_q != ST_CLR_ALL) || (sweep_row_q == CW'(ROWS-1)))) begin
        state_d = ST_IDLE;
      end else begin
        state_d = (state_q == ST_PUT) ? ST_CLR_ROW : state_q;
        if (sweep_col_q == CW'(COLS-1)) begin
          sweep_col_d = '0;
          sweep_row_d = sweep_row_q + 1'b1;
        end else begin
          sweep_col_d = sweep_col_q + 1'b1;
        end
      end
    end else begin
      // IDLE, or a PUT with no pending scroll: ready for the next byte.
      state_d = ST_IDLE;
      if (accept) begin
        if (is_printable(chr)) begin
          fb_we_d   = 1'b1;
          fb_addr_d = ag_addr;
          fb_data_d = chr;
          state_d   = ST_PUT;
          if (cur_x_q == CW'(COLS-1)) begin
            cur_x_d = '0;
            if (last_row) begin
              row_base_d    = row_base_inc;
              sweep_row_d   = row_base_q;
              sweep_col_d   = '0;
              pend_scroll_d = 1'b1;
            end else begin
              cur_y_d = cur_y_q + 1'b1;
            end
          end else begin
            cur_x_d = cur_x_q + 1'b1;
          end
        end else begin
          case (chr)
            CHR_CR: cur_x_d = '0;
            CHR_LF: begin
              cur_x_d = '0;
              if (last_row) begin
                row_base_d  = row_base_inc;
                sweep_row_d = row_base_q;  // old top row becomes new bottom
                sweep_col_d = '0;
                state_d     = ST_CLR_ROW;
              end else begin
                cur_y_d = cur_y_q + 1'b1;
              end
            end
            CHR_BS: begin
              if (cur_x_q != '0) begin
                cur_x_d = cur_x_q - 1'b1;
              end else if (cur_y_q != '0) begin
                cur_x_d = CW'(COLS-1);
                cur_y_d = cur_y_q - 1'b1;
              end
            end
            CHR_FF: begin
              cur_x_d     = '0;
              cur_y_d     = '0;
              row_base_d  = '0;
              sweep_row_d = '0;
              sweep_col_d = '0;
              state_d     = ST_CLR_ALL;
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge CLK_CPU or negedge RST) begin
    if (!RST) begin
      state_q       <= ST_IDLE;
      cur_x_q       <= '0;
      cur_y_q       <= '0;
      row_base_q    <= '0;
      sweep_row_q   <= '0;
      sweep_col_q   <= '0;
      pend_scroll_q <= 1'b0;
      fb_we_q       <= 1'b0;
      fb_addr_q     <= '0;
      fb_data_q     <= '0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_x_q       <= cur_x_d;
      cur_y_q       <= cur_y_d;
      row_base_q    <= row_base_d;
      sweep_row_q   <= sweep_row_d;
      sweep_col_q   <= sweep_col_d;
      pend_scroll_q <= pend_scroll_d;
      fb_we_q       <= fb_we_d;
      fb_addr_q     <= fb_addr_d;
      fb_data_q     <= fb_data_d;
      overrun_q     <= overrun_d;
    end
  end

  assign bus.FB_WE    = fb_we_q;
  assign bus.FB_ADDR  = fb_addr_q;
  assign bus.FB_DATA  = fb_data_q;
  assign bus.ROW_BASE = row_base_q;
  assign bus.CURSOR_X = cur_x_q;
  assign bus.CURSOR_Y = cur_y_q;
  assign bus.BUSY     = sweeping;
  assign bus.OVERRUN  = overrun_q;

endmodule

// File: tb/tb_text_term_ctrl.sv
module tb_text_term_ctrl;
  import text_term_pkg::*;

  typedef struct {
    logic [10:0] addr;
    logic [6:0]  data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   wr_seen = 0;
  exp_t exp_q[$];

  text_term_ctrl_if bus();

  text_term_ctrl dut (
    .CLK_CPU (clk),
    .RST     (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Monitor: every framebuffer write must match the next queued expectation.
  always @(negedge clk) begin
    if (rst_n && bus.FB_WE) begin
      wr_seen++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL fb_write: unexpected write addr=%0d data=%0h, none expected",
                 bus.FB_ADDR, bus.FB_DATA);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.FB_ADDR !== e.addr || bus.FB_DATA !== e.data) begin
          fails++;
          $display("FAIL fb_write: got addr=%0d data=%0h, expected addr=%0d data=%0h",
                   bus.FB_ADDR, bus.FB_DATA, e.addr, e.data);
        end
      end
    end
  end

  task automatic push(input int addr, input logic [6:0] data);
    exp_t e;
    e.addr = 11'(addr);
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic push_fill(input int first, input int n);
    for (int i = 0; i < n; i++) push(first + i, 7'h20);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_cur(input string name, input int x, input int y);
    chk({name, "_x"}, int'(bus.CURSOR_X), x);
    chk({name, "_y"}, int'(bus.CURSOR_Y), y);
  endtask

  // One enable cycle; returns on the negedge after the accepting posedge.
  task automatic wr(input logic [7:0] d);
    @(negedge clk);
    bus.CE = 1'b0; bus.RW = 1'b0; bus.DATA = d;
    @(negedge clk);
    bus.CE = 1'b1; bus.RW = 1'b1;
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (!bus.BUSY) break;
      @(negedge clk);
    end
    chk({name, "_idle"}, int'(bus.BUSY), 0);
    @(negedge clk);
    chk({name, "_drain"}, exp_q.size(), 0);
  endtask

  initial begin
    int run;
    int seen0;
    bus.CE = 1'b1; bus.RW = 1'b1; bus.DATA = 8'h00;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Reset values
    chk("rst_we", int'(bus.FB_WE), 0);
    chk("rst_addr", int'(bus.FB_ADDR), 0);
    chk("rst_data", int'(bus.FB_DATA), 0);
    chk("rst_rb", int'(bus.ROW_BASE), 0);
    chk_cur("rst_cur", 0, 0);
    chk("rst_busy", int'(bus.BUSY), 0);
    chk("rst_ovr", int'(bus.OVERRUN), 0);

    // First character, then 50 more to cross the row wrap
    push(0, 7'h41);
    wr(8'h41);
    chk_cur("put1_cur", 1, 0);
    for (int i = 1; i <= 50; i++) begin
      push(i, 7'h41);
      wr(8'h41);
    end
    chk_cur("put51_cur", 1, 1);

    // Clear screen, with a dropped write during the sweep
    push_fill(0, 1850);
    wr(8'h0C);
    chk("ff_busy", int'(bus.BUSY), 1);
    wr(8'h42);
    chk("ff_ovr", int'(bus.OVERRUN), 1);
    wait_idle("ff", 2000);
    chk_cur("ff_cur", 0, 0);
    chk("ff_rb", int'(bus.ROW_BASE), 0);

    // Backspace cases
    wr(8'h08);
    chk_cur("bs00_cur", 0, 0);
    wr(8'h0A);
    chk_cur("lf_cur", 0, 1);
    wr(8'h08);
    chk_cur("bs01_cur", 49, 0);
    push(49, 7'h44);
    wr(8'h44);
    chk_cur("bs_put_cur", 0, 1);

    // LF scroll from the last row
    for (int i = 0; i < 35; i++) wr(8'h0A);
    chk_cur("lf36_cur", 0, 36);
    push_fill(0, 50);
    wr(8'h0A);
    chk("lfs_rb", int'(bus.ROW_BASE), 1);
    chk("lfs_busy", int'(bus.BUSY), 1);
    wait_idle("lfs", 200);
    chk_cur("lfs_cur", 0, 36);
    push(0, 7'h43);
    wr(8'h43);
    chk_cur("lfs_put_cur", 1, 36);

    // Printable wrap on the last row: char write + row sweep back-to-back
    wr(8'h0D);
    chk_cur("cr_cur", 0, 36);
    for (int i = 0; i < 49; i++) begin
      push(i, 7'h61);
      wr(8'h61);
    end
    chk_cur("row_end_cur", 49, 36);
    push(49, 7'h62);
    push_fill(50, 50);
    wr(8'h62);
    chk("wrap_rb", int'(bus.ROW_BASE), 2);
    chk("wrap_busy", int'(bus.BUSY), 1);
    run = 0;
    while (bus.FB_WE && run < 60) begin
      run++;
      @(negedge clk);
    end
    chk("wrap_burst", run, 51);
    wait_idle("wrap", 100);
    chk_cur("wrap_cur", 0, 36);

    // Bit 7 ignored; non-printables ignored
    push(50, 7'h41);
    wr(8'hC1);
    chk_cur("b7_cur", 1, 36);
    wr(8'h7F);
    chk_cur("del_cur", 1, 36);
    wr(8'h01);
    chk_cur("soh_cur", 1, 36);
    chk("ign_rb", int'(bus.ROW_BASE), 2);

    // Reset in the middle of a clear-all sweep
    push_fill(0, 1850);
    seen0 = wr_seen;
    wr(8'h0C);
    for (int i = 0; i < 500; i++) begin
      if (wr_seen >= seen0 + 100) break;
      @(negedge clk);
    end
    chk("mid_reached", int'(wr_seen >= seen0 + 100), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_we", int'(bus.FB_WE), 0);
    chk("mid_rst_busy", int'(bus.BUSY), 0);
    chk("mid_rst_ovr", int'(bus.OVERRUN), 0);
    chk("mid_rst_rb", int'(bus.ROW_BASE), 0);
    chk_cur("mid_rst_cur", 0, 0);
    exp_q.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    push(0, 7'h41);
    wr(8'h41);
    @(negedge clk);
    chk("post_rst_drain", exp_q.size(), 0);
    chk_cur("post_rst_cur", 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Safety net so the run always ends
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, tests=%0d", tests);
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
